idct_odd_shift_add: RTL and testbench
=====================================

IDCT_ODD_SHIFT_ADD -- requirements
Module: idct_odd_shift_add

Interface
REQ-001 Parameter: WIDTH, default 26, signed sample width for all data ports.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 y1, y3, y5, y7  input  WIDTH each  signed odd-index DCT coefficients.
REQ-005 in_valid  input  1  coefficient set on y1..y7 is valid.
REQ-006 in_ready  output  1  block can accept a coefficient set.
REQ-007 o0, o1, o2, o3  output  WIDTH each  signed odd-part reconstruction terms, registered.
REQ-008 out_valid  output  1  o0..o3 hold a complete result.
REQ-009 out_ready  input  1  downstream accepts the result.

Function
REQ-010 Results SHALL be the transposed odd-part matrix:
- o0 = 89*y1 + 75*y3 + 50*y5 + 18*y7
- o1 = 75*y1 - 18*y3 - 89*y5 - 50*y7
- o2 = 50*y1 - 89*y3 + 18*y5 + 75*y7
- o3 = 18*y1 - 50*y3 + 75*y5 - 89*y7
REQ-011 Constant multiplies SHALL use shifts and adds only; no multiplier operators.
REQ-012 Internal sums SHALL be WIDTH+8 bits signed; results truncated (two's-complement wrap) to WIDTH.
REQ-013 FSM states: IDLE, CALC, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready at edge k, capture y1..y7 into input registers, go CALC, index=0.
REQ-015 CALC: in_ready=0; one output per cycle, o[index] written from captured inputs, index 0..3; after index 3 (edge k+4), go DONE.
REQ-016 DONE: out_valid=1 from edge k+4 until handshake; o0..o3 stable while out_valid&!out_ready.
REQ-017 On out_valid&out_ready, go IDLE; out_valid=0 and in_ready=1 next cycle; no same-cycle re-accept.
REQ-018 in_valid SHALL be ignored outside IDLE; input changes after capture SHALL NOT affect results.
REQ-019 o0..o3 SHALL retain last result in IDLE until overwritten during next CALC.
REQ-020 Throughput: one set per 6 cycles minimum with out_ready held high.

Reset
REQ-021 rst at any edge SHALL force IDLE, index=0, in_ready=1 next cycle, out_valid=0, o0..o3=0, input registers=0.
REQ-022 rst mid-CALC or in DONE SHALL discard the transaction; no partial result flagged valid.
REQ-023 rst SHALL take priority over simultaneous in_valid/out_ready handshakes.

Configuration
REQ-024 Macro IDCT_ROUND_EN defined: each output = (sum + 64) >>> 7 (arithmetic shift, round-half-up), then truncated to WIDTH.
REQ-025 IDCT_ROUND_EN undefined: each output = full-precision sum truncated to WIDTH; no rounding adder present.
REQ-026 Latency and handshake SHALL be identical in both builds.

Verification
REQ-027 Impulse: y1=1, others 0, out_ready=1 -> out_valid 4 cycles after accept, o0..o3 = 89,75,50,18 (round build: 1,1,0,0).
REQ-028 All-ones: y1=y3=y5=y7=1 -> o0..o3 = 232,-82,54,-46 (round build: 2,-1,0,0).
REQ-029 Back-pressure: out_ready=0 for 10 cycles in DONE -> outputs stable, out_valid=1, in_ready=0; in_valid pulses ignored; release -> IDLE next cycle.
REQ-030 Reset mid-CALC: rst at second CALC cycle -> next cycle IDLE, o0..o3=0, out_valid=0, in_ready=1; new set y7=1 -> 18,-50,75,-89.
REQ-031 Input hold-off: change y1..y7 during CALC -> results match values captured at accept.
REQ-032 Wrap: y1=2^(WIDTH-2), others 0, no-round build -> o0 = (89*2^(WIDTH-2)) mod 2^WIDTH as signed (=2^(WIDTH-2) for WIDTH=26).

Source files
------------

// File: rtl/idct_odd_shift_add.sv
// idct_odd_shift_add
// Odd-part 4x4 IDCT butterfly stage built from shifts and adds.
// A captured coefficient set produces one output term per cycle over four
// CALC cycles. The result is then held in DONE until the downstream accepts it.
// Optional build macro: IDCT_ROUND_EN. When it is defined, each output is
// rounded as (sum + 64) >>> 7 before truncation. When it is undefined, the
// full-precision sum is truncated to WIDTH.
module idct_odd_shift_add #(
    parameter int WIDTH = 26
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] y1,
    input  logic signed [WIDTH-1:0] y3,
    input  logic signed [WIDTH-1:0] y5,
    input  logic signed [WIDTH-1:0] y7,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] o0,
    output logic signed [WIDTH-1:0] o1,
    output logic signed [WIDTH-1:0] o2,
    output logic signed [WIDTH-1:0] o3,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Internal accumulation width: eight guard bits above the sample width.
    localparam int SW = WIDTH + 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic [1:0] index_reg, index_next;

    logic signed [WIDTH-1:0] y1_reg, y3_reg, y5_reg, y7_reg;
    logic signed [WIDTH-1:0] o_reg [4];

    logic signed [SW-1:0] y1_x, y3_x, y5_x, y7_x;
    logic signed [SW-1:0] lane_sum [4];

    logic accept;

    // Constant multiplies decomposed into powers of two.
    function automatic logic signed [SW-1:0] mul89(input logic signed [SW-1:0] x);
        return (x <<< 6) + (x <<< 4) + (x <<< 3) + x;
    endfunction

    function automatic logic signed [SW-1:0] mul75(input logic signed [SW-1:0] x);
        return (x <<< 6) + (x <<< 3) + (x <<< 1) + x;
    endfunction

    function automatic logic signed [SW-1:0] mul50(input logic signed [SW-1:0] x);
        return (x <<< 5) + (x <<< 4) + (x <<< 1);
    endfunction

    function automatic logic signed [SW-1:0] mul18(input logic signed [SW-1:0] x);
        return (x <<< 4) + (x <<< 1);
    endfunction

    // Reduce a wide sum to an output sample. Rounding happens only in the round build.
    function automatic logic signed [WIDTH-1:0] finish(input logic signed [SW-1:0] s);
`ifdef IDCT_ROUND_EN
        return WIDTH'((s + SW'(64)) >>> 7);
`else
        return WIDTH'(s);
`endif
    endfunction

    assign accept    = (state_reg == IDLE) && in_valid;
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);

    assign o0 = o_reg[0];
    assign o1 = o_reg[1];
    assign o2 = o_reg[2];
    assign o3 = o_reg[3];

    // Sign-extend the captured coefficients to the accumulation width.
    assign y1_x = SW'(y1_reg);
    assign y3_x = SW'(y3_reg);
    assign y5_x = SW'(y5_reg);
    assign y7_x = SW'(y7_reg);

    // Transposed odd-part matrix, one row per output lane.
    assign lane_sum[0] = mul89(y1_x) + mul75(y3_x) + mul50(y5_x) + mul18(y7_x);
    assign lane_sum[1] = mul75(y1_x) - mul18(y3_x) - mul89(y5_x) - mul50(y7_x);
    assign lane_sum[2] = mul50(y1_x) - mul89(y3_x) + mul18(y5_x) + mul75(y7_x);
    assign lane_sum[3] = mul18(y1_x) - mul50(y3_x) + mul75(y5_x) - mul89(y7_x);

    // State and lane index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            index_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            index_reg <= index_next;
        end
    end

    // Next-state logic: IDLE -> CALC on accept, four CALC cycles, DONE until taken.
    always_comb begin
        state_next = state_reg;
        index_next = index_reg;
        unique case (state_reg)
            IDLE: begin
                index_next = 2'd0;
                if (accept) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                index_next = index_reg + 2'd1;
                if (index_reg == 2'd3) begin
                    state_next = DONE;
                    index_next = 2'd0;
                end
            end
            DONE: begin
                index_next = 2'd0;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                index_next = 2'd0;
            end
        endcase
    end

    // Capture the coefficient set on accept. Later input changes are not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            y1_reg <= '0;
            y3_reg <= '0;
            y5_reg <= '0;
            y7_reg <= '0;
        end else if (accept) begin
            y1_reg <= y1;
            y3_reg <= y3;
            y5_reg <= y5;
            y7_reg <= y7;
        end
    end

    // Per-lane output registers. Each lane is written only in its CALC slot and holds otherwise.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    o_reg[gi] <= '0;
                end else if ((state_reg == CALC) && (index_reg == 2'(gi))) begin
                    o_reg[gi] <= finish(lane_sum[gi]);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_idct_odd_shift_add.sv
// Testbench for idct_odd_shift_add.
// A queue-based scoreboard is filled at accept time and drained when out_valid appears.
module tb_idct_odd_shift_add;

    localparam int W = 26;

    logic                clk = 1'b0;
    logic                rst;
    logic signed [W-1:0] y1, y3, y5, y7;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] o0, o1, o2, o3;
    logic                out_valid;
    logic                out_ready;

    int total = 0;
    int bad   = 0;
    logic signed [W-1:0] exp_q [$];

    idct_odd_shift_add #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .y1(y1), .y3(y3), .y5(y5), .y7(y7),
        .in_valid(in_valid), .in_ready(in_ready),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference model computed in full precision with ordinary multiplies.
    function automatic logic signed [W-1:0] model(input int lane, input longint a, input longint b,
                                                  input longint c, input longint d);
        longint s;
        case (lane)
            0: s = 89*a + 75*b + 50*c + 18*d;
            1: s = 75*a - 18*b - 89*c - 50*d;
            2: s = 50*a - 89*b + 18*c + 75*d;
            default: s = 18*a - 50*b + 75*c - 89*d;
        endcase
`ifdef IDCT_ROUND_EN
        s = (s + 64) >>> 7;
`endif
        return W'(s);
    endfunction

    // Offer a set, wait until it is accepted, and optionally record its expected result.
    task automatic send(input logic signed [W-1:0] a, b, c, d, input bit push);
        int n = 0;
        y1 = a; y3 = b; y5 = c; y7 = d;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_ready", {63'd0, in_ready}, 64'sd1);
        tick();
        in_valid = 1'b0;
        if (push) begin
            for (int l = 0; l < 4; l++) exp_q.push_back(model(l, a, b, c, d));
        end
    endtask

    // Wait for out_valid, check the latency, and compare the outputs against the scoreboard.
    task automatic collect(input string tag);
        int lat = 0;
        logic signed [W-1:0] e [4];
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        for (int l = 0; l < 4; l++) e[l] = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_o0"}, o0, e[0]);
        check({tag, "_o1"}, o1, e[1]);
        check({tag, "_o2"}, o2, e[2]);
        check({tag, "_o3"}, o3, e[3]);
        $display("txn %s: o0=%0d o1=%0d o2=%0d o3=%0d latency=%0d", tag, o0, o1, o2, o3, lat);
    endtask

    // With out_ready high, the handshake completes at the next edge and IDLE follows.
    task automatic release_check(input string tag);
        tick();
        check({tag, "_ov_after"}, {63'd0, out_valid}, 64'sd0);
        check({tag, "_ir_after"}, {63'd0, in_ready}, 64'sd1);
    endtask

    initial begin
        logic signed [W-1:0] h0, h1, h2, h3;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        y1 = '0; y3 = '0; y5 = '0; y7 = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", {63'd0, out_valid}, 64'sd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'sd1);
        check("rst_o0", o0, 0);
        check("rst_o3", o3, 0);

        // Impulse
        send(1, 0, 0, 0, 1);
        collect("impulse");
`ifdef IDCT_ROUND_EN
        check("impulse_lit_o0", o0, 1);
        check("impulse_lit_o3", o3, 0);
`else
        check("impulse_lit_o0", o0, 89);
        check("impulse_lit_o3", o3, 18);
`endif
        release_check("impulse");

        // All-ones
        send(1, 1, 1, 1, 1);
        collect("ones");
`ifdef IDCT_ROUND_EN
        check("ones_lit_o1", o1, -1);
`else
        check("ones_lit_o1", o1, -82);
        check("ones_lit_o3", o3, -46);
`endif
        release_check("ones");

        // Mixed-sign pattern
        send(-1234, 567, -89, 32000, 1);
        collect("mixed");
        release_check("mixed");

        // Back-pressure: hold DONE for 10 cycles and pulse in_valid meanwhile
        out_ready = 1'b0;
        send(300, -200, 100, -50, 1);
        collect("bp");
        h0 = o0; h1 = o1; h2 = o2; h3 = o3;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            y1 = W'(i * 7 + 1); y3 = W'(-i); y5 = W'(i); y7 = W'(99);
            tick();
            check("bp_out_valid", {63'd0, out_valid}, 64'sd1);
            check("bp_in_ready", {63'd0, in_ready}, 64'sd0);
            check("bp_hold", {o0, o1, o2, o3}, {h0, h1, h2, h3});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        release_check("bp");
        check("bp_keep_o0", o0, h0);

        // Reset during the second CALC cycle discards the transaction
        send(5, 6, 7, 8, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ov", {63'd0, out_valid}, 64'sd0);
        check("midrst_ir", {63'd0, in_ready}, 64'sd1);
        check("midrst_o", {o0, o1, o2, o3}, {4*W{1'b0}});
        $display("txn midrst: o0=%0d o1=%0d o2=%0d o3=%0d", o0, o1, o2, o3);
        send(0, 0, 0, 1, 1);
        collect("y7");
`ifdef IDCT_ROUND_EN
        check("y7_lit", {o0, o1, o2, o3}, {W'(0), W'(0), W'(1), W'(-1)});
`else
        check("y7_lit", {o0, o1, o2, o3}, {W'(18), W'(-50), W'(75), W'(-89)});
`endif
        release_check("y7");

        // Input hold-off: inputs change throughout CALC
        send(11, -22, 33, -44, 1);
        for (int i = 0; i < 3; i++) begin
            y1 = W'($urandom); y3 = W'($urandom); y5 = W'($urandom); y7 = W'($urandom);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        begin
            // Three CALC cycles have already elapsed.
            int lat = 3;
            while (!out_valid && lat < 20) begin
                tick();
                lat++;
            end
            check("hold_latency", lat, 4);
            check("hold_o0", o0, exp_q.pop_front());
            check("hold_o1", o1, exp_q.pop_front());
            check("hold_o2", o2, exp_q.pop_front());
            check("hold_o3", o3, exp_q.pop_front());
            $display("txn hold: o0=%0d o1=%0d o2=%0d o3=%0d", o0, o1, o2, o3);
        end
        release_check("hold");

        // Wrap: y1 = 2^(W-2)
        send(W'(1) <<< (W - 2), 0, 0, 0, 1);
        collect("wrap");
`ifndef IDCT_ROUND_EN
        check("wrap_lit_o0", o0, 64'sd1 <<< (W - 2));
`endif
        release_check("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
